// File: rtl/bpu_btb_if.sv
// Fetch/execute side bundle for the branch target buffer:
// lookup PC and prediction, flush, and resolved-branch training.
interface bpu_btb_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic              prdt_taken_o;
  logic [ADDR_W-1:0] prdt_addr_o;
  logic              flush_i;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_taken_i;
  logic              upd_uncond_i;

  modport master (
    output pc_i,
    output flush_i,
    output upd_valid_i,
    output upd_pc_i,
    output upd_target_i,
    output upd_taken_i,
    output upd_uncond_i,
    input  prdt_taken_o,
    input  prdt_addr_o
  );

  modport slave (
    input  pc_i,
    input  flush_i,
    input  upd_valid_i,
    input  upd_pc_i,
    input  upd_target_i,
    input  upd_taken_i,
    input  upd_uncond_i,
    output prdt_taken_o,
    output prdt_addr_o
  );
endinterface

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit saturating counters, feeding
// the PC register with a zero-latency next-fetch prediction.
module bpu_btb #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  bpu_btb_if.slave   btb
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [1:0]         ctr_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q  [ENTRIES];
  logic [ENTRIES-1:0] unc_q;

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic             l_taken;

  assign l_idx = btb.pc_i[IDX_W+1:2];
  assign l_tag = btb.pc_i[ADDR_W-1:IDX_W+2];
  assign l_hit = valid_q[l_idx]
               & (tag_q[l_idx] == l_tag)
               & (btb.pc_i[1:0] == 2'b00);
  assign l_taken = l_hit
                 & (unc_q[l_idx] | ctr_q[l_idx][1]);

  assign btb.prdt_taken_o = l_taken & ~rst;
  assign btb.prdt_addr_o  = btb.prdt_taken_o
                          ? tgt_q[l_idx]
                          : btb.pc_i + ADDR_W'(4);

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_en;
  logic             u_hit;
  logic             u_taken;
  logic             wr;
  logic             tgt_wr;
  logic [1:0]       ctr_d;

  assign u_idx   = btb.upd_pc_i[IDX_W+1:2];
  assign u_tag   = btb.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign u_en    = btb.upd_valid_i
                 & (btb.upd_pc_i[1:0] == 2'b00);
  assign u_hit   = valid_q[u_idx]
                 & (tag_q[u_idx] == u_tag);
  // jal/jalr reported as not-taken is coerced to taken
  assign u_taken = btb.upd_taken_i | btb.upd_uncond_i;

  always_comb begin
    wr     = 1'b0;
    tgt_wr = 1'b0;
    ctr_d  = ctr_q[u_idx];
    if (u_en && u_hit) begin
      wr     = 1'b1;
      tgt_wr = u_taken;
      if (u_taken)
        ctr_d = (ctr_q[u_idx] == 2'b11)
              ? 2'b11 : ctr_q[u_idx] + 2'b01;
      else
        ctr_d = (ctr_q[u_idx] == 2'b00)
              ? 2'b00 : ctr_q[u_idx] - 2'b01;
    end else if (u_en && u_taken) begin
      wr     = 1'b1;
      tgt_wr = 1'b1;
      ctr_d  = btb.upd_uncond_i ? 2'b11 : 2'b10;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (wr)
      valid_d[u_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
    end else if (btb.flush_i) begin
      valid_q <= '0;
    end else if (wr) begin
      valid_q      <= valid_d;
      ctr_q[u_idx] <= ctr_d;
    end
  end

  // payload needs no reset: valid gates every use
  always_ff @(posedge clk) begin
    if (!rst && !btb.flush_i && wr) begin
      tag_q[u_idx] <= u_tag;
      unc_q[u_idx] <= btb.upd_uncond_i;
      if (tgt_wr)
        tgt_q[u_idx] <= btb.upd_target_i;
    end
  end
endmodule

// File: doc/bpu_btb.md
Name: bpu_btb

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Sits directly upstream of the PC register.
- Each cycle it looks up the current fetch PC and drives the PC register's predict-taken flag and predicted next address.
- It is trained by resolved branch/jump outcomes from the execute stage.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- ADDR_W, 32, instruction address width.
- Derived, local only:
  - IDX_W = log2(ENTRIES).
  - TAG_W = ADDR_W-2-IDX_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- pc_i  input  ADDR_W  current fetch PC, from the PC register output.
- prdt_taken_o  output  1  prediction: fetch PC is a taken branch/jump.
- prdt_addr_o  output  ADDR_W  predicted next fetch address.
- flush_i  input  1  invalidate all entries (fence.i / jtag reset).
- upd_valid_i  input  1  execute stage resolved a branch or jump this cycle.
- upd_pc_i  input  ADDR_W  PC of the resolved instruction.
- upd_target_i  input  ADDR_W  resolved target address.
- upd_taken_i  input  1  resolved direction.
- upd_uncond_i  input  1  instruction is jal/jalr (always taken).

Behaviour:
- Entry contents: valid, tag[TAG_W], target[ADDR_W], ctr[1:0], uncond.
- Index and tag, for both lookup and update:
  - idx = addr[IDX_W+1:2].
  - tag = addr[ADDR_W-1:IDX_W+2].
- Lookup (combinational from pc_i and registered table; zero latency):
  - hit = valid[idx] & (tag[idx] == pc tag) & (pc_i[1:0] == 2'b00).
  - prdt_taken_o = hit & (uncond[idx] | ctr[idx][1]).
  - prdt_addr_o = target[idx] when prdt_taken_o, else pc_i + 4. Modulo 2^ADDR_W: 0xFFFFFFFC -> 0x00000000.
- Update (sequential, visible to lookup from the cycle after upd_valid_i). Only when upd_valid_i=1 and upd_pc_i[1:0]==0:
  - Hit on upd_pc_i:
    - upd_taken_i=1: ctr saturating increment, max 2'b11; target <= upd_target_i.
    - upd_taken_i=0: ctr saturating decrement, min 2'b00; target unchanged.
    - uncond <= upd_uncond_i in both cases.
  - Miss with upd_taken_i=1: allocate or overwrite the entry at idx, replacing any aliasing entry:
    - valid <= 1, tag <= upd tag, target <= upd_target_i, uncond <= upd_uncond_i.
    - ctr <= 2'b10 (weakly taken), or 2'b11 if upd_uncond_i.
  - Miss with upd_taken_i=0: no change.
  - upd_uncond_i=1 with upd_taken_i=0 is illegal input; treat it as taken.
- No bypass: a lookup and an update to the same entry in the same cycle return the old contents.
- Reset (rst=1 at a clock edge):
  - All valid <= 0, all ctr <= 2'b01; tag/target contents don't-care.
  - While rst=1, prdt_taken_o is forced to 0 and prdt_addr_o = pc_i + 4.
  - An update presented during reset is dropped.
- flush_i=1: all valid <= 0 in one cycle; ctr, tag and target are not touched.
- Priority at a clock edge: rst > flush_i > update. A flush in the same cycle as an update discards the update.
- Stall or hold in the PC register needs no special handling: the lookup is purely combinational, so repeated lookups of the same pc_i give the same result.
- Table storage is flops. ENTRIES <= 64 is assumed synthesizable as registers.

Test Plan:
- Cold lookup: rst for 2 cycles, then pc_i=0x100 -> prdt_taken_o=0, prdt_addr_o=0x104; pc_i=0xFFFFFFFC -> prdt_addr_o=0x00000000.
- Allocate and predict:
  - Update pc=0x100, target=0x200, taken=1, uncond=0.
  - Same cycle, pc_i=0x100 -> taken=0 (no bypass).
  - Next cycle -> taken=1, addr=0x200 (ctr=10).
- Counter hysteresis:
  - From ctr=10: two taken updates -> ctr=11, then one not-taken -> ctr=10, still predicts 0x200.
  - A second not-taken -> ctr=01: taken=0, addr=0x104.
  - Three further not-taken -> ctr stays 00.
- Aliasing: entry at 0x100 valid; pc_i=0x140 (same idx 0, different tag) -> taken=0, addr=0x144.
  - Then taken update pc=0x140, target=0x300 -> 0x140 predicts 0x300 and 0x100 now misses.
- Unconditional and misaligned:
  - Update pc=0x80, target=0x40, taken=1, uncond=1 -> pc_i=0x80 predicts 0x40.
  - A subsequent not-taken update with uncond=0 -> ctr=10, still taken.
  - pc_i=0x82 -> no prediction.
- Flush and reset priority:
  - flush_i together with an update to pc=0x10 -> next cycle every valid entry misses, including 0x10.
  - rst asserted mid-run with entries valid -> all lookups taken=0 after the reset edge.
